// File: rtl/ftoi_sched.sv
// Round-robin two-port sequencer for the fixed-latency float-to-int converter.
// One conversion in flight; operands held stable in cv_*, result returned over valid/ready.
module ftoi_sched #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 24,
    parameter int INT_W = 32,
    parameter int LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   r0_valid,
    output logic                   r0_ready,
    input  logic [EXP_W+SIG_W-1:0] r0_a,
    input  logic [2:0]             r0_rm,
    input  logic                   r0_signed,
    input  logic                   r1_valid,
    output logic                   r1_ready,
    input  logic [EXP_W+SIG_W-1:0] r1_a,
    input  logic [2:0]             r1_rm,
    input  logic                   r1_signed,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [INT_W-1:0]       rsp_out,
    output logic [2:0]             rsp_flags,
    output logic                   cv_control,
    output logic [EXP_W+SIG_W-1:0] cv_a,
    output logic [2:0]             cv_rm,
    output logic                   cv_signed,
    input  logic [INT_W-1:0]       cv_out,
    input  logic [2:0]             cv_flags
);

    localparam int A_W   = EXP_W + SIG_W;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t             state_q;
    logic               prio_q;
    logic               owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [A_W-1:0]     cv_a_q;
    logic [2:0]         cv_rm_q;
    logic               cv_signed_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [INT_W-1:0]   rsp_out_q;
    logic [2:0]         rsp_flags_q;

    logic               can_grant;
    logic               win_id;

    // Ready is the grant itself: only one of the two can be high at a time.
    assign can_grant = (state_q == IDLE) && !flush;
    assign r0_ready  = can_grant && r0_valid && (!prio_q || !r1_valid);
    assign r1_ready  = can_grant && r1_valid && ( prio_q || !r0_valid);
    assign win_id    = r1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            cv_a_q      <= '0;
            cv_rm_q     <= '0;
            cv_signed_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
        end else if (flush) begin
            // Abort drops any held result; operands and priority are left as they are.
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r0_ready || r1_ready) begin
                        cv_a_q      <= win_id ? r1_a      : r0_a;
                        cv_rm_q     <= win_id ? r1_rm     : r0_rm;
                        cv_signed_q <= win_id ? r1_signed : r0_signed;
                        owner_q     <= win_id;
                        prio_q      <= ~win_id;
                        cnt_q       <= CNT_W'(LAT - 1);
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rsp_out_q   <= cv_out;
                        rsp_flags_q <= cv_flags;
                        rsp_id_q    <= owner_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cv_control = 1'b0;
    assign cv_a       = cv_a_q;
    assign cv_rm      = cv_rm_q;
    assign cv_signed  = cv_signed_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_ftoi_sched.sv
// Directed bench for ftoi_sched: converter stub, expected-response queue and a
// monitor that checks each delivered response against it.
module tb_ftoi_sched;

    localparam int EXP_W = 8;
    localparam int SIG_W = 24;
    localparam int INT_W = 32;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_a = '0, r1_a = '0;
    logic [2:0]  r0_rm = '0, r1_rm = '0;
    logic        r0_signed = 1'b0, r1_signed = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [31:0] rsp_out;
    logic [2:0]  rsp_flags;
    logic        cv_control;
    logic [31:0] cv_a;
    logic [2:0]  cv_rm;
    logic        cv_signed;
    logic [31:0] cv_out;
    logic [2:0]  cv_flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] out;
        logic [2:0]  fl;
    } exp_t;
    exp_t exp_q[$];

    ftoi_sched #(.EXP_W(EXP_W), .SIG_W(SIG_W), .INT_W(INT_W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_rm(r0_rm), .r0_signed(r0_signed),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_rm(r1_rm), .r1_signed(r1_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags),
        .cv_control(cv_control), .cv_a(cv_a), .cv_rm(cv_rm), .cv_signed(cv_signed),
        .cv_out(cv_out), .cv_flags(cv_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Converter stub: only the operands used below are known to it.
    always_comb begin
        cv_out   = 32'h0;
        cv_flags = 3'b000;
        case (cv_a)
            32'h406CCCCD: begin cv_out = 32'd4; cv_flags = 3'b001; end
            32'h3F800000: begin cv_out = 32'd1; cv_flags = 3'b000; end
            32'h40000000: begin cv_out = 32'd2; cv_flags = 3'b000; end
            32'h7FC00000, 32'h4F800000: begin
                cv_out   = cv_signed ? 32'h7FFFFFFF : 32'hFFFFFFFF;
                cv_flags = 3'b100;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake is a delivery only if flush is not overriding it.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_out", rsp_out, e.out);
                chk("rsp_flags", rsp_flags, e.fl);
            end
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [31:0] a,
                           input logic [2:0] rm, input bit sg);
        if (!id) begin r0_valid = v; r0_a = a; r0_rm = rm; r0_signed = sg; end
        else     begin r1_valid = v; r1_a = a; r1_rm = rm; r1_signed = sg; end
    endtask

    // Raise a request, wait (bounded) for its grant, optionally queue the expected
    // response. Returns just after the granting edge with the request dropped.
    task automatic issue(input bit id, input logic [31:0] a, input logic [2:0] rm, input bit sg,
                         input bit push, input logic [31:0] eo, input logic [2:0] ef,
                         output int waited);
        bit got;
        got = 0;
        waited = 0;
        @(posedge clk); #1;
        set_req(id, 1'b1, a, rm, sg);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id ? r1_ready : r0_ready) begin got = 1; waited = i; break; end
        end
        chk("grant_seen", got, 1);
        if (push) exp_q.push_back({id, eo, ef});
        @(posedge clk); #1;
        set_req(id, 1'b0, a, rm, sg);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        int last;
        bit got;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_cv_a", cv_a, 0);
        chk("rst_cv_rm", cv_rm, 0);
        chk("rst_cv_signed", cv_signed, 0);
        chk("cv_control", cv_control, 0);
        rst_n = 1'b1;

        // Single conversion: 3.7 RNE signed -> 4, inexact
        rsp_ready = 1'b1;
        issue(1'b0, 32'h406CCCCD, 3'd0, 1'b1, 1'b1, 32'd4, 3'b001, w);
        chk("single_ready_cycle0", w, 0);
        chk("single_cv_a", cv_a, 32'h406CCCCD);
        chk("single_cv_signed", cv_signed, 1);
        @(negedge clk);
        chk("single_busy_novalid", rsp_valid, 0);
        @(negedge clk);
        chk("single_valid_lat", rsp_valid, 1);
        drain();

        // Contention from reset: alternating grants, LAT+2 apart
        do_reset();
        set_req(1'b0, 1'b1, 32'h3F800000, 3'd0, 1'b1);
        set_req(1'b1, 1'b1, 32'h40000000, 3'd0, 1'b1);
        last = 0;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (r0_ready || r1_ready) begin got = 1; break; end
            end
            chk("cont_grant_seen", got, 1);
            chk("cont_winner", {r1_ready, r0_ready}, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) chk("cont_spacing", cyc - last, LAT + 2);
            last = cyc;
            exp_q.push_back({1'(k % 2), (k % 2) ? 32'd2 : 32'd1, 3'b000});
            @(posedge clk);
        end
        #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        drain();

        // Backpressure: response held 5 cycles with a competing request pending
        rsp_ready = 1'b0;
        issue(1'b0, 32'h40000000, 3'd0, 1'b1, 1'b1, 32'd2, 3'b000, w);
        set_req(1'b1, 1'b1, 32'h7FC00000, 3'd1, 1'b1);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        chk("bp_valid_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_out_stable", rsp_out, 32'd2);
            chk("bp_id_stable", rsp_id, 0);
            chk("bp_no_ready", {r1_ready, r0_ready}, 2'b00);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // Invalid operand on r1 (already pending): NaN signed
        issue(1'b1, 32'h7FC00000, 3'd1, 1'b1, 1'b1, 32'h7FFFFFFF, 3'b100, w);
        chk("nan_cv_rm", cv_rm, 3'd1);
        drain();

        // Out of range unsigned: 2^32
        issue(1'b0, 32'h4F800000, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 3'b100, w);
        chk("ovf_cv_signed", cv_signed, 0);
        drain();

        // Flush while BUSY: nothing emitted, next request served
        issue(1'b0, 32'h3F800000, 3'd0, 1'b1, 1'b0, 32'd0, 3'b000, w);
        flush = 1'b1;
        set_req(1'b1, 1'b1, 32'h40000000, 3'd0, 1'b1);
        @(negedge clk);
        chk("flush_no_ready", r1_ready, 0);
        chk("flush_no_valid", rsp_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_valid", rsp_valid, 0);
        chk("flush_next_ready", r1_ready, 1);
        exp_q.push_back({1'b1, 32'd2, 3'b000});
        @(posedge clk); #1;
        r1_valid = 1'b0;
        drain();

        // Flush on a would-be grant
        flush = 1'b1;
        set_req(1'b0, 1'b1, 32'h3F800000, 3'd0, 1'b1);
        @(negedge clk);
        chk("flush_blocks_grant", r0_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("after_flush_grant", r0_ready, 1);
        exp_q.push_back({1'b0, 32'd1, 3'b000});
        @(posedge clk); #1;
        r0_valid = 1'b0;
        drain();

        // Reset in HOLD: async drop of rsp_valid, prio back to 0
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3F800000, 3'd0, 1'b1, 1'b0, 32'd0, 3'b000, w);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        chk("hold_reached", got, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", rsp_valid, 0);
        chk("rst_async_out", rsp_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(1'b0, 1'b1, 32'h3F800000, 3'd0, 1'b1);
        set_req(1'b1, 1'b1, 32'h40000000, 3'd0, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_prio_zero", {r1_ready, r0_ready}, 2'b01);
        exp_q.push_back({1'b0, 32'd1, 3'b000});
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
